// File: rtl/fcpu_pkg.sv
// Shared core definitions: data widths, opcode encodings and the data-memory-unit types.
package fcpu_pkg;

    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_NOP     = 6'd0;
    localparam logic [INSTR_W-1:0] I_ADD     = 6'd1;
    localparam logic [INSTR_W-1:0] I_SUB     = 6'd2;
    localparam logic [INSTR_W-1:0] I_LOAD    = 6'd16;
    localparam logic [INSTR_W-1:0] I_LOADR   = 6'd17;
    localparam logic [INSTR_W-1:0] I_LOADF   = 6'd18;
    localparam logic [INSTR_W-1:0] I_LOADRF  = 6'd19;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'd20;
    localparam logic [INSTR_W-1:0] I_LOADBF  = 6'd21;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'd24;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'd25;
    localparam logic [INSTR_W-1:0] I_STOREF  = 6'd26;
    localparam logic [INSTR_W-1:0] I_STORERF = 6'd27;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'd28;
    localparam logic [INSTR_W-1:0] I_STOREBF = 6'd29;
    localparam logic [INSTR_W-1:0] I_INPUT   = 6'd32;
    localparam logic [INSTR_W-1:0] I_INPUTF  = 6'd33;
    localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'd34;

    typedef enum logic [2:0] {
        DMU_IDLE,
        DMU_ISSUE,
        DMU_RWAIT,
        DMU_IN_WAIT,
        DMU_OUT_WAIT,
        DMU_RESP
    } dmu_state_t;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [INSTR_W-1:0]  opcode;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } mmu_req_t;

    function automatic logic is_byte_op(input logic [INSTR_W-1:0] op);
        return op inside {I_LOADB, I_LOADBF, I_STOREB, I_STOREBF};
    endfunction

    function automatic logic is_load_op(input logic [INSTR_W-1:0] op);
        return op inside {I_LOAD, I_LOADR, I_LOADF, I_LOADRF, I_LOADB, I_LOADBF};
    endfunction

    function automatic logic is_store_op(input logic [INSTR_W-1:0] op);
        return op inside {I_STORE, I_STORER, I_STOREF, I_STORERF, I_STOREB, I_STOREBF};
    endfunction

    function automatic logic is_input_op(input logic [INSTR_W-1:0] op);
        return op inside {I_INPUT, I_INPUTF};
    endfunction

endpackage

// File: rtl/dmu_lane_align.sv
// Byte-lane steering for the data RAM: store write-enables/replication and
// little-endian byte extraction with zero-extension for loads.
module dmu_lane_align
    import fcpu_pkg::*;
(
    input  logic              byte_op_i,
    input  logic [1:0]        lane_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_word_i,
    output logic [3:0]        we_mask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o
);

    always_comb begin
        we_mask_o = 4'hF;
        wdata_o   = st_data_i;
        ld_data_o = ld_word_i;
        if (byte_op_i) begin
            // Replicating the byte lets the RAM ignore lane position; the mask picks the lane.
            we_mask_o = 4'b0001 << lane_i;
            wdata_o   = {4{st_data_i[7:0]}};
            ld_data_o = {{(DATA_W-8){1'b0}}, ld_word_i[{lane_i, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Non-pipelined memory unit: executes one MFU load/store/input/output request at a time
// against a synchronous data RAM or the byte streams, returning load/input results on the CDB.
module data_memory_unit
    import fcpu_pkg::*;
#(
    parameter int RAM_ADDR_W  = 14,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [RSV_ID_W-1:0]   mmu_rsv_id,
    input  logic                  mmu_valid,
    input  logic [DATA_W-1:0]     mmu_data,
    input  logic [DATA_W-1:0]     mmu_addr,
    input  logic [INSTR_W-1:0]    mmu_opcode,
    output logic                  mmu_ready,
    output logic [CDB_W-1:0]      mmu_cdb,
    output logic                  mmu_cdb_valid,
    input  logic                  mmu_cdb_ready,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_opcode,
    output dmu_state_t            dbg_state
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    dmu_state_t        state_q, state_d;
    mmu_req_t          req_q, req_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic              err_q, err_d;

    logic [3:0]        we_mask;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;
    logic              req_is_store;
    logic              unused_addr_hi;

    dmu_lane_align u_lane_align (
        .byte_op_i (is_byte_op(req_q.opcode)),
        .lane_i    (req_q.addr[1:0]),
        .st_data_i (req_q.data),
        .ld_word_i (ram_rdata),
        .we_mask_o (we_mask),
        .wdata_o   (st_wdata),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= DMU_IDLE;
            req_q     <= '0;
            result_q  <= '0;
            lat_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            result_q  <= result_d;
            lat_cnt_q <= lat_cnt_d;
            err_q     <= err_d;
        end
    end

    // Handshakes: a transfer happens on the rising edge where both valid and ready are high;
    // the producer holds valid and its payload stable until that edge.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        result_d  = result_q;
        lat_cnt_d = lat_cnt_q;
        err_d     = err_q;
        case (state_q)
            DMU_IDLE: begin
                if (mmu_valid) begin
                    if (is_load_op(mmu_opcode) || is_store_op(mmu_opcode)) begin
                        state_d = DMU_ISSUE;
                    end else if (is_input_op(mmu_opcode)) begin
                        state_d = DMU_IN_WAIT;
                    end else if (mmu_opcode == I_OUTPUT) begin
                        state_d = DMU_OUT_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (state_d != DMU_IDLE) begin
                        req_d = '{rsv_id: mmu_rsv_id, opcode: mmu_opcode,
                                  addr: mmu_addr, data: mmu_data};
                    end
                end
            end
            DMU_ISSUE: begin
                lat_cnt_d = '0;
                state_d   = is_load_op(req_q.opcode) ? DMU_RWAIT : DMU_IDLE;
            end
            DMU_RWAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    result_d = ld_data;
                    state_d  = DMU_RESP;
                end else begin
                    lat_cnt_d = 2'(lat_cnt_q + 2'd1);
                end
            end
            DMU_IN_WAIT: begin
                if (in_valid) begin
                    result_d = {{(DATA_W-8){1'b0}}, in_data};
                    state_d  = DMU_RESP;
                end
            end
            DMU_OUT_WAIT: begin
                if (out_ready) state_d = DMU_IDLE;
            end
            DMU_RESP: begin
                // The CDB grant can be withheld for any time; the result simply waits here.
                if (mmu_cdb_ready) state_d = DMU_IDLE;
            end
            default: state_d = DMU_IDLE;
        endcase
    end

    assign req_is_store   = is_store_op(req_q.opcode);
    assign unused_addr_hi = ^req_q.addr[DATA_W-1:RAM_ADDR_W+2];

    assign mmu_ready     = (state_q == DMU_IDLE);
    assign ram_en        = (state_q == DMU_ISSUE);
    assign ram_we        = (ram_en && req_is_store) ? we_mask : 4'h0;
    assign ram_addr      = ram_en ? req_q.addr[RAM_ADDR_W+1:2] : '0;
    assign ram_wdata     = (ram_en && req_is_store) ? st_wdata : '0;
    assign mmu_cdb_valid = (state_q == DMU_RESP);
    assign mmu_cdb       = mmu_cdb_valid ? {req_q.rsv_id, result_q} : '0;
    assign in_ready      = (state_q == DMU_IN_WAIT);
    assign out_valid     = (state_q == DMU_OUT_WAIT);
    assign out_data      = out_valid ? req_q.data[7:0] : 8'h00;
    assign err_opcode    = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: two instances (RAM latency 1 and 3), a reference
// memory model with expected queues, a per-cycle compare process and literal checks.
`timescale 1ns/1ps
module tb_data_memory_unit;
    import fcpu_pkg::*;

    localparam int AW   = 14;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic nrst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [RSV_ID_W-1:0] mmu_rsv_id [2];
    logic                mmu_valid [2];
    logic [DATA_W-1:0]   mmu_data [2];
    logic [DATA_W-1:0]   mmu_addr [2];
    logic [INSTR_W-1:0]  mmu_opcode [2];
    logic                mmu_ready [2];
    logic [CDB_W-1:0]    mmu_cdb [2];
    logic                mmu_cdb_valid [2];
    logic                mmu_cdb_ready [2];
    logic                ram_en [2];
    logic [3:0]          ram_we [2];
    logic [AW-1:0]       ram_addr [2];
    logic [DATA_W-1:0]   ram_wdata [2];
    logic [DATA_W-1:0]   ram_rdata [2];
    logic [7:0]          in_data [2];
    logic                in_valid [2];
    logic                in_ready [2];
    logic [7:0]          out_data [2];
    logic                out_valid [2];
    logic                out_ready [2];
    logic                err_opcode [2];
    dmu_state_t          dbg_state [2];

    data_memory_unit #(.RAM_ADDR_W(AW), .RAM_LATENCY(LAT0)) dut0 (
        .clk(clk), .nrst(nrst), .mmu_rsv_id(mmu_rsv_id[0]), .mmu_valid(mmu_valid[0]),
        .mmu_data(mmu_data[0]), .mmu_addr(mmu_addr[0]), .mmu_opcode(mmu_opcode[0]),
        .mmu_ready(mmu_ready[0]), .mmu_cdb(mmu_cdb[0]), .mmu_cdb_valid(mmu_cdb_valid[0]),
        .mmu_cdb_ready(mmu_cdb_ready[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .err_opcode(err_opcode[0]), .dbg_state(dbg_state[0])
    );

    data_memory_unit #(.RAM_ADDR_W(AW), .RAM_LATENCY(LAT1)) dut1 (
        .clk(clk), .nrst(nrst), .mmu_rsv_id(mmu_rsv_id[1]), .mmu_valid(mmu_valid[1]),
        .mmu_data(mmu_data[1]), .mmu_addr(mmu_addr[1]), .mmu_opcode(mmu_opcode[1]),
        .mmu_ready(mmu_ready[1]), .mmu_cdb(mmu_cdb[1]), .mmu_cdb_valid(mmu_cdb_valid[1]),
        .mmu_cdb_ready(mmu_cdb_ready[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .err_opcode(err_opcode[1]), .dbg_state(dbg_state[1])
    );

    // RAM models: read data appears LATn cycles after the enable edge; junk otherwise.
    logic [DATA_W-1:0] mem0 [0:(1<<AW)-1];
    logic [DATA_W-1:0] mem1 [0:(1<<AW)-1];
    logic [DATA_W-1:0] pipe0 [LAT0];
    logic [DATA_W-1:0] pipe1 [LAT1];

    always @(posedge clk) begin
        if (ram_en[0]) begin
            pipe0[0] <= mem0[ram_addr[0]];
            for (int b = 0; b < 4; b++)
                if (ram_we[0][b]) mem0[ram_addr[0]][8*b +: 8] <= ram_wdata[0][8*b +: 8];
        end else begin
            pipe0[0] <= 32'hA5A5_5A5A;
        end
        for (int i = 1; i < LAT0; i++) pipe0[i] <= pipe0[i-1];
    end

    always @(posedge clk) begin
        if (ram_en[1]) begin
            pipe1[0] <= mem1[ram_addr[1]];
            for (int b = 0; b < 4; b++)
                if (ram_we[1][b]) mem1[ram_addr[1]][8*b +: 8] <= ram_wdata[1][8*b +: 8];
        end else begin
            pipe1[0] <= 32'hA5A5_5A5A;
        end
        for (int i = 1; i < LAT1; i++) pipe1[i] <= pipe1[i-1];
    end

    assign ram_rdata[0] = pipe0[LAT0-1];
    assign ram_rdata[1] = pipe1[LAT1-1];

    // Scoreboard
    int tests = 0;
    int fails = 0;
    logic [CDB_W-1:0]        exp_cdb_q [$];
    logic [AW+4+DATA_W-1:0]  exp_wr_q [$];
    logic [7:0]              exp_out_q [$];
    logic [DATA_W-1:0]       ref_mem [int];
    int                      exp_en [2];
    int                      got_en [2];
    logic [CDB_W-1:0]        last_cdb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : '0;
    endfunction

    // Compare process
    logic             prev_valid [2];
    logic             prev_grant [2];
    logic [CDB_W-1:0] prev_cdb [2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!nrst) begin
                prev_valid[u] = 1'b0;
                prev_grant[u] = 1'b0;
            end else begin
                if (!mmu_cdb_valid[u]) begin
                    check("cdb_zero_when_idle", mmu_cdb[u], 0);
                end else begin
                    check("ready_low_in_resp", mmu_ready[u], 0);
                    if (prev_valid[u] && !prev_grant[u]) check("cdb_stable", mmu_cdb[u], prev_cdb[u]);
                    if (mmu_cdb_ready[u]) begin
                        if (exp_cdb_q.size() == 0) check("cdb_unexpected", mmu_cdb[u], 0);
                        else check("cdb_packet", mmu_cdb[u], exp_cdb_q.pop_front());
                        last_cdb = mmu_cdb[u];
                    end
                end
                prev_valid[u] = mmu_cdb_valid[u];
                prev_grant[u] = mmu_cdb_ready[u];
                prev_cdb[u]   = mmu_cdb[u];
                if (ram_en[u]) begin
                    got_en[u]++;
                    if (ram_we[u] != 4'h0) begin
                        if (exp_wr_q.size() == 0) check("ram_write_unexpected", ram_we[u], 0);
                        else check("ram_write", {ram_addr[u], ram_we[u], ram_wdata[u]}, exp_wr_q.pop_front());
                    end
                end
                if (out_valid[u]) begin
                    if (exp_out_q.size() == 0) check("out_unexpected", out_data[u], 0);
                    else if (out_ready[u]) check("out_data", out_data[u], exp_out_q.pop_front());
                    else check("out_data_held", out_data[u], exp_out_q[0]);
                end
            end
        end
    end

    // Driver: updates the reference model, then presents the request until accepted.
    task automatic send(input int u, input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] id,
                        input logic [31:0] addr, input logic [31:0] data, input logic [7:0] in_byte,
                        output int t_acc);
        int          key;
        int          lane;
        logic [31:0] w;
        key  = u * 65536 + int'(addr[AW+1:2]);
        lane = int'(addr[1:0]);
        w    = ref_rd(key);
        if (op inside {I_LOAD, I_LOADR, I_LOADF, I_LOADRF}) begin
            exp_cdb_q.push_back({id, w});
            exp_en[u]++;
        end else if (op inside {I_LOADB, I_LOADBF}) begin
            exp_cdb_q.push_back({id, 24'h0, w[8*lane +: 8]});
            exp_en[u]++;
        end else if (op inside {I_STORE, I_STORER, I_STOREF, I_STORERF}) begin
            ref_mem[key] = data;
            exp_wr_q.push_back({addr[AW+1:2], 4'hF, data});
            exp_en[u]++;
        end else if (op inside {I_STOREB, I_STOREBF}) begin
            w[8*lane +: 8] = data[7:0];
            ref_mem[key] = w;
            exp_wr_q.push_back({addr[AW+1:2], 4'(1 << lane), {4{data[7:0]}}});
            exp_en[u]++;
        end else if (op inside {I_INPUT, I_INPUTF}) begin
            exp_cdb_q.push_back({id, 24'h0, in_byte});
        end else if (op == I_OUTPUT) begin
            exp_out_q.push_back(data[7:0]);
        end
        mmu_valid[u] = 1'b1; mmu_opcode[u] = op; mmu_rsv_id[u] = id;
        mmu_addr[u] = addr; mmu_data[u] = data;
        t_acc = -1;
        for (int i = 0; i < 50 && t_acc < 0; i++) begin
            @(negedge clk);
            if (mmu_ready[u]) begin
                @(posedge clk); #1;
                t_acc = cyc;
            end
        end
        mmu_valid[u] = 1'b0;
        if (t_acc < 0) check("accept_timeout", 1, 0);
    endtask

    // Returns the index of the first edge at which the CDB packet can be granted.
    task automatic wait_cdb(input int u, output int grant_edge);
        grant_edge = -1;
        for (int i = 0; i < 40 && grant_edge < 0; i++) begin
            @(negedge clk);
            if (mmu_cdb_valid[u]) grant_edge = cyc + 1;
        end
        if (grant_edge < 0) check("cdb_timeout", 1, 0);
    endtask

    task automatic settle();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic load_check(input int u, input logic [INSTR_W-1:0] op, input logic [3:0] id,
                              input logic [31:0] addr, input logic [CDB_W-1:0] lit, input int lat,
                              input string name);
        int ta;
        int ge;
        send(u, op, id, addr, 0, 0, ta);
        wait_cdb(u, ge);
        @(posedge clk); #1;
        check({name, "_latency"}, ge - ta, lat);
        check({name, "_value"}, last_cdb, lit);
    endtask

    initial begin
        int ta;
        int ge;
        nrst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mmu_valid[u] = 0; mmu_rsv_id[u] = 0; mmu_data[u] = 0; mmu_addr[u] = 0;
            mmu_opcode[u] = I_NOP; mmu_cdb_ready[u] = 1; in_data[u] = 0; in_valid[u] = 0;
            out_ready[u] = 0; exp_en[u] = 0; got_en[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("rst_ready", mmu_ready[0], 1);
        check("rst_cdb_valid", mmu_cdb_valid[0], 0);
        check("rst_ram_en", ram_en[0], 0);
        check("rst_err", err_opcode[0], 0);
        check("rst_in_ready", in_ready[0], 0);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_state0", dbg_state[0], DMU_IDLE);
        check("rst_state1", dbg_state[1], DMU_IDLE);

        // Word store then load
        @(posedge clk); #1;
        send(0, I_STORE, 0, 32'h10, 32'hDEAD_BEEF, 0, ta);
        settle();
        load_check(0, I_LOAD, 5, 32'h10, {4'd5, 32'hDEAD_BEEF}, 3, "load_word");

        // Byte store into lane 3, byte load, word reload
        send(0, I_STOREB, 0, 32'h13, 32'h0000_007A, 0, ta);
        settle();
        load_check(0, I_LOADB, 2, 32'h13, {4'd2, 32'h0000_007A}, 3, "load_byte");
        load_check(0, I_LOAD, 1, 32'h10, {4'd1, 32'h7AAD_BEEF}, 3, "load_merged");

        // Address wrap above the RAM, and addr[1:0] ignored on word load
        send(0, I_STOREF, 0, 32'h0001_0040, 32'h1122_3344, 0, ta);
        settle();
        load_check(0, I_LOADF, 11, 32'h43, {4'd11, 32'h1122_3344}, 3, "load_wrap");
        load_check(0, I_LOADBF, 12, 32'h41, {4'd12, 32'h0000_0033}, 3, "load_byte_lane1");

        // CDB grant withheld for 10 cycles
        mmu_cdb_ready[0] = 1'b0;
        send(0, I_LOAD, 9, 32'h10, 0, 0, ta);
        wait_cdb(0, ge);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", mmu_cdb_valid[0], 1);
            check("hold_not_ready", mmu_ready[0], 0);
            check("hold_data", mmu_cdb[0], {4'd9, 32'h7AAD_BEEF});
        end
        @(posedge clk); #1 mmu_cdb_ready[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("release_ready", mmu_ready[0], 1);
        check("release_valid", mmu_cdb_valid[0], 0);

        // Input stream with a 5-cycle gap
        @(posedge clk); #1;
        send(0, I_INPUT, 3, 0, 0, 8'h41, ta);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_ready_wait", in_ready[0], 1);
        end
        @(posedge clk); #1 in_data[0] = 8'h41; in_valid[0] = 1'b1;
        @(posedge clk); #1 in_valid[0] = 1'b0; in_data[0] = 8'h00;
        wait_cdb(0, ge);
        @(posedge clk); #1;
        check("input_value", last_cdb, {4'd3, 32'h0000_0041});

        // Output stream with out_ready low for 3 cycles
        send(0, I_OUTPUT, 4, 0, 32'h0000_1234, 0, ta);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("out_valid_held", out_valid[0], 1);
            check("out_data_literal", out_data[0], 8'h34);
        end
        @(posedge clk); #1 out_ready[0] = 1'b1;
        @(posedge clk); #1 out_ready[0] = 1'b0;
        @(negedge clk);
        check("out_done_valid", out_valid[0], 0);
        check("out_done_ready", mmu_ready[0], 1);
        check("out_no_cdb", mmu_cdb_valid[0], 0);
        check("out_q_drained", exp_out_q.size(), 0);

        // Unsupported opcode: sticky error, no side effects, next load fine
        @(posedge clk); #1;
        send(0, I_ADD, 6, 32'h10, 32'hFFFF_FFFF, 0, ta);
        @(negedge clk);
        check("err_set", err_opcode[0], 1);
        check("err_back_idle", mmu_ready[0], 1);
        check("err_no_ram", ram_en[0], 0);
        @(posedge clk); #1;
        load_check(0, I_LOAD, 6, 32'h10, {4'd6, 32'h7AAD_BEEF}, 3, "load_after_err");
        check("err_sticky", err_opcode[0], 1);

        // Reset for 2 edges while holding a result
        mmu_cdb_ready[0] = 1'b0;
        send(0, I_LOADR, 7, 32'h10, 0, 0, ta);
        wait_cdb(0, ge);
        @(posedge clk); #1 nrst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst2_cdb_valid", mmu_cdb_valid[0], 0);
        check("rst2_cdb", mmu_cdb[0], 0);
        check("rst2_ready", mmu_ready[0], 1);
        check("rst2_ram_en", ram_en[0], 0);
        check("rst2_err", err_opcode[0], 0);
        void'(exp_cdb_q.pop_back());
        nrst = 1'b1;
        mmu_cdb_ready[0] = 1'b1;
        @(posedge clk); #1;

        // RAM latency 3 instance
        send(1, I_STORE, 0, 32'h20, 32'hCAFE_F00D, 0, ta);
        settle();
        load_check(1, I_LOAD, 4, 32'h20, {4'd4, 32'hCAFE_F00D}, 5, "l3_load_word");
        load_check(1, I_LOADB, 8, 32'h21, {4'd8, 32'h0000_00F0}, 5, "l3_load_byte");
        send(1, I_STOREBF, 0, 32'h20, 32'h0000_0099, 0, ta);
        settle();
        load_check(1, I_LOADRF, 10, 32'h23, {4'd10, 32'hCAFE_F099}, 5, "l3_load_merged");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ram_en_count0", got_en[0], exp_en[0]);
        check("ram_en_count1", got_en[1], exp_en[1]);
        check("cdb_q_drained", exp_cdb_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
